// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns MEM-stage load/store requests into word-aligned
// req/ack bus transactions, extends load data and stalls the pipeline meanwhile.
module dmem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Wdata_in,
  input  logic [2:0]  DMType,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [2:0]       type_reg;
  logic [1:0]       off_reg;

  logic        req;
  logic        is_half;
  logic        is_byte;
  logic        aligned;
  logic        accept;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] ld_next;

  assign req     = mem_r | mem_w;
  assign is_half = (DMType == 3'b001) || (DMType == 3'b010);
  assign is_byte = (DMType == 3'b011) || (DMType == 3'b100);
  // Codes 101-111 fall through to word handling.
  assign aligned = is_byte | (is_half & ~Addr_in[0]) | (~is_half & ~is_byte & (Addr_in[1:0] == 2'b00));
  assign accept   = (state_reg == IDLE) & req & aligned;
  assign misalign = (state_reg == IDLE) & req & ~aligned;
  assign stall    = accept | (state_reg == BUSY);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = Wdata_in;
    if (is_half) begin
      be_next    = 4'b0011 << Addr_in[1:0];
      wdata_next = {2{Wdata_in[15:0]}};
    end else if (is_byte) begin
      be_next    = 4'b0001 << Addr_in[1:0];
      wdata_next = {4{Wdata_in[7:0]}};
    end
  end

  assign half_sel = mem_rdata[{off_reg[1], 4'b0000} +: 16];
  assign byte_sel = mem_rdata[{off_reg, 3'b000} +: 8];

  always_comb begin
    case (type_reg)
      3'b001:  ld_next = {{16{half_sel[15]}}, half_sel};
      3'b010:  ld_next = {16'h0000, half_sel};
      3'b011:  ld_next = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_next = {24'h000000, byte_sel};
      default: ld_next = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      type_reg  <= 3'b000;
      off_reg   <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      ld_data   <= 32'h0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done    <= 1'b0;
          bus_err <= 1'b0;
          if (accept) begin
            state_reg <= BUSY;
            count_reg <= '0;
            type_reg  <= DMType;
            off_reg   <= Addr_in[1:0];
            mem_req   <= 1'b1;
            mem_we    <= mem_w;
            mem_addr  <= {Addr_in[31:2], 2'b00};
            mem_be    <= be_next;
            mem_wdata <= wdata_next;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state_reg <= S_DONE;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            if (!mem_we) ld_data <= ld_next;
          end else if (count_reg == CNT_W'(TIMEOUT - 1)) begin
            state_reg <= S_DONE;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            bus_err   <= 1'b1;
            ld_data   <= 32'h0;
          end else begin
            count_reg <= count_reg + CNT_W'(1);
          end
        end
        S_DONE: begin
          // Unconditional return; a request still held here is not re-accepted.
          state_reg <= IDLE;
          done      <= 1'b0;
          bus_err   <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed plan cases plus random accesses checked
// against an arithmetic reference of lane selection, extension and timing.
module tb_dmem_access_unit;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset, mem_r, mem_w, mem_ack;
  logic [31:0] Addr_in, Wdata_in, mem_rdata;
  logic [2:0]  DMType;
  logic        stall, done, misalign, bus_err, mem_req, mem_we;
  logic [31:0] ld_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_ld = 32'h0;

  dmem_access_unit #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w),
    .Addr_in(Addr_in), .Wdata_in(Wdata_in), .DMType(DMType),
    .stall(stall), .ld_data(ld_data), .done(done), .misalign(misalign),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int acc_size(input logic [2:0] t);
    if (t == 3'd3 || t == 3'd4) return 1;
    if (t == 3'd1 || t == 3'd2) return 2;
    return 4;
  endfunction

  function automatic bit model_aligned(input logic [31:0] a, input logic [2:0] t);
    return (int'(a[1:0]) % acc_size(t)) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [2:0] t);
    int n;
    n = acc_size(t);
    return 4'(((1 << n) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] w, input logic [2:0] t);
    int n;
    n = acc_size(t);
    if (n == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    if (n == 1) return (w & 32'hFF) * 32'h0101_0101;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] t);
    logic [31:0] s, mask, v;
    int n;
    n = acc_size(t);
    if (n == 4) return rd;
    s    = rd >> (8 * int'(a[1:0]));
    mask = (n == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    v    = s & mask;
    if ((t == 3'd1 || t == 3'd3) && ((v & ~(mask >> 1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  // Runs one access starting in IDLE, #1 after an edge; delay >= TMO means no ack.
  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] t, input int delay, input logic [31:0] rd, input string tag);
    int  stalls;
    bit  al, tmo;
    al  = model_aligned(a, t);
    tmo = (delay >= TMO);
    mem_r = r; mem_w = w; Addr_in = a; Wdata_in = wd; DMType = t;
    #1;
    check({tag, "_misalign"}, 32'(misalign), 32'(!al));
    check({tag, "_stall0"}, 32'(stall), 32'(al));
    if (!al) begin
      check({tag, "_noreq"}, 32'(mem_req), 32'h0);
      step();
      mem_r = 1'b0; mem_w = 1'b0;
      #1;
      check({tag, "_noreq2"}, 32'(mem_req), 32'h0);
      check({tag, "_ld_keep"}, ld_data, exp_ld);
      check({tag, "_nodone"}, 32'(done), 32'h0);
      $display("[TB] %s r=%0d w=%0d addr=%h type=%0d misaligned", tag, r, w, a, t);
      return;
    end
    stalls = 1;
    for (int k = 0; k < TMO; k++) begin
      step();
      if (k == 0) begin
        check({tag, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
        check({tag, "_be"}, 32'(mem_be), 32'(model_be(a, t)));
        check({tag, "_wdata"}, mem_wdata, model_wdata(wd, t));
        check({tag, "_we"}, 32'(mem_we), 32'(w));
        check({tag, "_req"}, 32'(mem_req), 32'h1);
      end
      mem_rdata = (k == delay) ? rd : $urandom;
      mem_ack   = (k == delay);
      #1;
      check({tag, "_busy_done"}, 32'(done), 32'h0);
      if (stall) stalls++;
      if (k == delay) break;
    end
    step();
    mem_ack = 1'b0;
    #1;
    if (tmo) exp_ld = 32'h0;
    else if (!w) exp_ld = model_load(rd, a, t);
    check({tag, "_done"}, 32'(done), 32'h1);
    check({tag, "_buserr"}, 32'(bus_err), 32'(tmo));
    check({tag, "_stall_done"}, 32'(stall), 32'h0);
    check({tag, "_req_off"}, 32'(mem_req), 32'h0);
    check({tag, "_ld"}, ld_data, exp_ld);
    check({tag, "_stall_cycles"}, 32'(stalls), tmo ? 32'(TMO + 1) : 32'(delay + 2));
    step();
    mem_r = 1'b0; mem_w = 1'b0;
    #1;
    check({tag, "_idle_done"}, 32'(done), 32'h0);
    check({tag, "_idle_err"}, 32'(bus_err), 32'h0);
    check({tag, "_idle_req"}, 32'(mem_req), 32'h0);
    $display("[TB] %s r=%0d w=%0d addr=%h type=%0d delay=%0d ld=%h stalls=%0d",
             tag, r, w, a, t, delay, ld_data, stalls);
  endtask

  initial begin
    reset = 1'b1; mem_r = 1'b0; mem_w = 1'b0; mem_ack = 1'b0;
    Addr_in = 32'h0; Wdata_in = 32'h0; DMType = 3'd0; mem_rdata = 32'h0;
    step(); step();
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_ld", ld_data, 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_be", 32'(mem_be), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    reset = 1'b0;
    step();

    access(1'b0, 1'b1, 32'h0000_1003, 32'h0000_00A5, 3'd3, 2, 32'h0, "st_byte");
    check("st_byte_be_const", 32'(mem_be), 32'h8);
    check("st_byte_wd_const", mem_wdata, 32'hA5A5_A5A5);
    access(1'b1, 1'b0, 32'h0000_2002, 32'h0, 3'd1, 0, 32'h8001_1234, "ld_half_s");
    check("ld_half_s_const", ld_data, 32'hFFFF_8001);
    check("ld_half_s_be", 32'(mem_be), 32'hC);
    access(1'b1, 1'b0, 32'h0000_2001, 32'h0, 3'd4, 0, 32'h0000_F000, "ld_byte_u");
    check("ld_byte_u_const", ld_data, 32'h0000_00F0);
    access(1'b1, 1'b0, 32'h0000_2001, 32'h0, 3'd3, 1, 32'h0000_F000, "ld_byte_s");
    check("ld_byte_s_const", ld_data, 32'hFFFF_FFF0);
    access(1'b1, 1'b0, 32'h0000_0003, 32'h0, 3'd0, 0, 32'h0, "mis_word");
    access(1'b1, 1'b0, 32'h0000_0005, 32'h0, 3'd2, 0, 32'h0, "mis_half");
    check("mis_ld_const", ld_data, 32'hFFFF_FFF0);
    access(1'b1, 1'b0, 32'h0000_4000, 32'h0, 3'd0, 99, 32'h0, "timeout");
    check("timeout_ld_const", ld_data, 32'h0);

    // Stray ack while idle must be ignored.
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    #1;
    check("idle_ack_done", 32'(done), 32'h0);
    check("idle_ack_ld", ld_data, exp_ld);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] rw;
      int d;
      rw = 2'($urandom_range(1, 3));
      d  = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 5));
      access(rw[0], rw[1], $urandom, $urandom, 3'($urandom_range(0, 7)), d, $urandom, "rand");
    end

    // Reset during the second BUSY cycle abandons the access.
    mem_r = 1'b1; mem_w = 1'b0; Addr_in = 32'h0000_5000; DMType = 3'd0;
    step();
    step();
    check("mid_req_busy", 32'(mem_req), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0; mem_r = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    exp_ld = 32'h0;
    check("mid_rst_req", 32'(mem_req), 32'h0);
    check("mid_rst_we", 32'(mem_we), 32'h0);
    check("mid_rst_addr", mem_addr, 32'h0);
    check("mid_rst_be", 32'(mem_be), 32'h0);
    check("mid_rst_wdata", mem_wdata, 32'h0);
    check("mid_rst_ld", ld_data, 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_stall", 32'(stall), 32'h0);
    step();
    check("late_ack_done", 32'(done), 32'h0);
    check("late_ack_ld", ld_data, exp_ld);
    mem_ack = 1'b0;
    step();
    check("late_ack_done2", 32'(done), 32'h0);
    $display("[TB] mid-access reset done=%0d ld=%h", done, ld_data);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Sits directly downstream of the pipelined CPU's MEM stage, between the core's data-memory outputs and a variable-latency data memory/bus.
- Core inputs consumed: mem_w, Addr_out, Data_out, DMType, plus a read strobe.
- Generates word-aligned requests with byte enables and lane-replicated store data; handshakes with memory via req/ack.
- Sign/zero-extends load data and stalls the pipeline until the access completes, times out, or is rejected as misaligned.

Parameters:
TIMEOUT, 16, max BUSY cycles without mem_ack before bus error (>=2).
CNT_W, 5, width of timeout counter (must hold TIMEOUT).

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous active-high reset
mem_r  input  1  load request from MEM stage
mem_w  input  1  store request from MEM stage
Addr_in  input  32  byte address (ALU result)
Wdata_in  input  32  store data (rs2 value)
DMType  input  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned
stall  output  1  freeze PC and pipeline registers
ld_data  output  32  extended load result to MEM/WB
done  output  1  one-cycle completion pulse
misalign  output  1  misaligned access rejected
bus_err  output  1  one-cycle timeout pulse, coincident with done
mem_req  output  1  memory request
mem_we  output  1  1=write
mem_addr  output  32  {Addr_in[31:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  read data, valid with mem_ack
mem_ack  input  1  memory completion

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, ld_data, done, bus_err, counter all 0.
  - Reset mid-BUSY abandons the access; no done pulse follows.
- Request: req = mem_r | mem_w. If both are high, treat as a store.
- Alignment:
  - Word needs Addr_in[1:0]=00; half needs Addr_in[0]=0; byte is always aligned.
  - DMType 101–111 is treated as word.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req and aligned -> BUSY next edge. Latch mem_addr, mem_we=mem_w, mem_be, mem_wdata, DMType, Addr_in[1:0]; mem_req<=1; counter<=0.
  - req and misaligned -> stay IDLE. No memory access; misalign=1 combinationally.
- BUSY:
  - mem_ack=1 -> DONE. mem_req<=0. For loads, ld_data<=extend(mem_rdata); for stores ld_data is unchanged.
  - No ack and counter==TIMEOUT-1 -> DONE. mem_req<=0, bus_err<=1, ld_data<=0.
  - Otherwise counter+1.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. The request still present on the inputs during DONE is not re-accepted.
- stall (combinational) = (IDLE & req & aligned) | BUSY. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Minimum latency, ack in first BUSY cycle: stall for 2 cycles, done in cycle 3.
- mem_addr, mem_we, mem_be and mem_wdata hold stable while mem_req=1.
- Byte enables (o = Addr_in[1:0]):
  - word: 1111
  - half: 0011<<o
  - byte: 0001<<o
- Store data:
  - word: unchanged
  - half: {2{Wdata_in[15:0]}}
  - byte: {4{Wdata_in[7:0]}}
- Load: s = mem_rdata >> (8*o).
  - Half signed/unsigned: sign- or zero-extend s[15:0].
  - Byte signed/unsigned: sign- or zero-extend s[7:0].
  - Word: mem_rdata.
- mem_ack outside BUSY is ignored.
- ld_data holds its value until the next completed load or reset.

Test Plan:
- Store byte: mem_w=1, Addr_in=0x1003, Wdata_in=0x000000A5, DMType=011 -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1; ack after 3 cycles -> stall high 4 cycles, done pulse 1 cycle.
- Load half signed: Addr_in=0x2002, DMType=001, ack in first BUSY cycle with mem_rdata=0x80011234 -> mem_be=1100, ld_data=0xFFFF8001, done in cycle 3.
- Load byte unsigned: Addr_in=0x2001, DMType=100, mem_rdata=0x0000F000 -> ld_data=0x000000F0. Repeat with DMType=011 -> ld_data=0xFFFFFFF0.
- Misaligned: mem_r=1, Addr_in=0x3, DMType=000 -> misalign=1, stall=0, mem_req stays 0, ld_data unchanged. Repeat with half at 0x5 -> same.
- Timeout: load, mem_ack held 0 -> after 16 BUSY cycles: bus_err=1 and done=1 same cycle, ld_data=0, mem_req=0, then IDLE.
- Reset mid-access: reset asserted in BUSY cycle 2 -> next edge all outputs 0, state IDLE, no done. Late mem_ack after reset is ignored.
